// File: rtl/alu_exec_if.sv
// Handshake and operand/result bundle between the control sequencer and the execution stage.
interface alu_exec_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] regA;
  logic [WIDTH-1:0] regB;
  logic [WIDTH-1:0] opcode;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output start, regA, regB, opcode,
    input  busy, done, result, flags
  );

  modport slave (
    input  start, regA, regB, opcode,
    output busy, done, result, flags
  );
endinterface

// File: rtl/alu_exec.sv
// Execution stage: single-cycle logic/arith ops plus iterative shift-add MUL and restoring DIV/MOD,
// result and {Z,C,N,E} flags held in a buffer register until the next completion.
module alu_exec #(
  parameter int WIDTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  alu_exec_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ITER, S_FINISH} state_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
    OP_XOR = 4'd4, OP_NOT = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7,
    OP_MUL = 4'd8, OP_DIV = 4'd9, OP_MOD = 4'd10
  } op_t;

  state_t           r_state, w_next;
  op_t              r_op;
  logic [WIDTH-1:0] r_a, r_b;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic             r_done;

  logic             w_iter_req;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_sh;
  logic [WIDTH:0]   w_div_sub;
  logic             w_div_ge;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_e;
  logic             w_unused;

  assign w_iter_req = (bus.opcode[3:0] == OP_MUL || bus.opcode[3:0] == OP_DIV ||
                       bus.opcode[3:0] == OP_MOD) && (bus.regB != '0);

  // MUL: {hi,lo} is the partial product, multiplier bits shift out of lo as product bits enter.
  // DIV/MOD: hi is the running remainder, lo shifts dividend bits out and quotient bits in.
  assign w_mul_sum = {1'b0, r_hi} + {1'b0, r_a};
  assign w_div_sh  = {r_hi, r_lo[WIDTH-1]};
  assign w_div_ge  = (w_div_sh >= {1'b0, r_b});
  assign w_div_sub = w_div_sh - {1'b0, r_b};
  assign w_add     = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff    = {1'b0, r_a} - {1'b0, r_b};
  assign w_unused  = ^{bus.opcode[WIDTH-1:4], w_div_sub[WIDTH]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_next = w_iter_req ? S_ITER : S_EXEC;
      S_EXEC:   w_next = S_IDLE;
      S_ITER:   if (r_cnt == LAST) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_e   = 1'b0;
    if (r_state == S_FINISH) begin
      case (r_op)
        OP_MUL: begin
          w_res = r_lo;
          w_c   = |r_hi;
        end
        OP_MOD:  w_res = r_hi;
        default: w_res = r_lo;
      endcase
    end else begin
      case (r_op)
        OP_ADD: begin
          w_res = w_add[WIDTH-1:0];
          w_c   = w_add[WIDTH];
        end
        OP_SUB: begin
          w_res = w_diff[WIDTH-1:0];
          w_c   = w_diff[WIDTH];
        end
        OP_AND: w_res = r_a & r_b;
        OP_OR:  w_res = r_a | r_b;
        OP_XOR: w_res = r_a ^ r_b;
        OP_NOT: w_res = ~r_a;
        OP_SHL: begin
          w_res = {r_a[WIDTH-2:0], 1'b0};
          w_c   = r_a[WIDTH-1];
        end
        OP_SHR: begin
          w_res = {1'b0, r_a[WIDTH-1:1]};
          w_c   = r_a[0];
        end
        // Only a zero multiplier or divisor reaches EXEC for these three.
        OP_MUL: w_res = '0;
        OP_DIV: begin
          w_res = '1;
          w_e   = 1'b1;
        end
        OP_MOD: begin
          w_res = r_a;
          w_e   = 1'b1;
        end
        default: w_e = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_op     <= OP_ADD;
      r_a      <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_flags  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op  <= op_t'(bus.opcode[3:0]);
            r_a   <= bus.regA;
            r_b   <= bus.regB;
            r_hi  <= '0;
            r_lo  <= (bus.opcode[3:0] == OP_MUL) ? bus.regB : bus.regA;
            r_cnt <= '0;
          end
        end
        S_ITER: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_op == OP_MUL) begin
            if (r_lo[0]) begin
              r_hi <= w_mul_sum[WIDTH:1];
              r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
            end else begin
              r_hi <= {1'b0, r_hi[WIDTH-1:1]};
              r_lo <= {r_hi[0], r_lo[WIDTH-1:1]};
            end
          end else begin
            r_hi <= w_div_ge ? w_div_sub[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], w_div_ge};
          end
        end
        S_EXEC, S_FINISH: begin
          r_result <= w_res;
          r_flags  <= {(w_res == '0), w_c, w_res[WIDTH-1], w_e};
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (r_state != S_IDLE);
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.flags  = r_flags;
endmodule
